// File: rtl/rr_grant_arbiter_pkg.sv
// rr_grant_arbiter shared types: FSM state enum and round-robin pick.
// next_rr(req, last, n) returns the first set req index after last, wrapping at n-1.
package rr_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  localparam int MAX_ENTRY = 64;

  typedef logic [MAX_ENTRY-1:0] req_vec_t;

  // Scan downward so the last hit is the entry closest after 'last';
  // 'last' itself is visited at i==n and so has the lowest priority.
  function automatic int next_rr(
    input req_vec_t req,
    input int       last,
    input int       n
  );
    int res;
    int idx;
    res = last;
    for (int i = MAX_ENTRY; i >= 1; i--) begin
      if (i <= n) begin
        idx = last + i;
        if (idx >= n) idx = idx - n;
        if (req[idx[5:0]]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter request/grant bundle.
// master: requesters (drive I_Req/I_Rls); slave: the arbiter (drives O_*).
interface rr_grant_arbiter_if #(
  parameter int NUM_ENTRY     = 8,
  parameter int LOG_NUM_ENTRY = 3
);
  logic [NUM_ENTRY-1:0]     I_Req;
  logic [NUM_ENTRY-1:0]     I_Rls;
  logic [NUM_ENTRY-1:0]     O_Grt;
  logic [LOG_NUM_ENTRY-1:0] O_Grt_No;
  logic                     O_Vld;
  logic                     O_Tmo;

  modport master (
    output I_Req, I_Rls,
    input  O_Grt, O_Grt_No, O_Vld, O_Tmo
  );

  modport slave (
    input  I_Req, I_Rls,
    output O_Grt, O_Grt_No, O_Vld, O_Tmo
  );
endinterface

// File: rtl/rr_grant_arbiter_decoder.sv
// Owner index to one-hot grant decoder, gated by en.
// Ports: en, idx in; onehot out (all-zero when en=0).
module rr_grant_arbiter_decoder #(
  parameter int NUM_ENTRY     = 8,
  parameter int LOG_NUM_ENTRY = 3
) (
  input  logic                     en,
  input  logic [LOG_NUM_ENTRY-1:0] idx,
  output logic [NUM_ENTRY-1:0]     onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      onehot[i] = en && (idx == LOG_NUM_ENTRY'(i));
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter: holds grant until owner releases, then rotates.
// Ports: clock, reset (async low), arb (slave modport). Macro: RRARB_TIMEOUT_EN.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NUM_ENTRY     = 8,
  parameter int LOG_NUM_ENTRY = 3,
  parameter int TIMEOUT       = 256,
  parameter int LOG_TIMEOUT   = 8
) (
  input logic               clock,
  input logic               reset,
  rr_grant_arbiter_if.slave arb
);

  typedef logic [LOG_NUM_ENTRY-1:0] idx_t;

  if (NUM_ENTRY < 2 || TIMEOUT < 2 ||
      (1 << LOG_NUM_ENTRY) < NUM_ENTRY ||
      (1 << LOG_TIMEOUT) < TIMEOUT) begin : g_bad_cfg
    $error("rr_grant_arbiter: bad parameters");
  end

  arb_state_t state_q, state_d;
  idx_t       owner_q, owner_d;
  idx_t       last_q, last_d;
  logic       normal_rls;
  logic       expire;

`ifdef RRARB_TIMEOUT_EN
  logic [LOG_TIMEOUT-1:0] cnt_q, cnt_d;
  logic                   tmo_q, tmo_d;

  assign expire = (state_q == ARB_BUSY) &&
                  (cnt_q == LOG_TIMEOUT'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif

  assign normal_rls = arb.I_Rls[owner_q] | ~arb.I_Req[owner_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef RRARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (|arb.I_Req) begin
          owner_d = idx_t'(next_rr(req_vec_t'(arb.I_Req),
                                   int'(last_q), NUM_ENTRY));
          state_d = ARB_BUSY;
`ifdef RRARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_BUSY: begin
        if (normal_rls || expire) begin
          state_d = ARB_IDLE;
          last_d  = owner_q;
`ifdef RRARB_TIMEOUT_EN
          // A genuine release in the expiry cycle is not a timeout.
          tmo_d   = expire & ~normal_rls;
`endif
        end else begin
`ifdef RRARB_TIMEOUT_EN
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= idx_t'(NUM_ENTRY - 1);
`ifdef RRARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef RRARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign arb.O_Vld    = (state_q == ARB_BUSY);
  assign arb.O_Grt_No = owner_q;
`ifdef RRARB_TIMEOUT_EN
  assign arb.O_Tmo    = tmo_q;
`else
  assign arb.O_Tmo    = 1'b0;
`endif

  rr_grant_arbiter_decoder #(
    .NUM_ENTRY     (NUM_ENTRY),
    .LOG_NUM_ENTRY (LOG_NUM_ENTRY)
  ) u_dec (
    .en     (arb.O_Vld),
    .idx    (owner_q),
    .onehot (arb.O_Grt)
  );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Testbench for rr_grant_arbiter: directed steps then random traffic
// against a behavioural arbiter model.
module tb_rr_grant_arbiter;

  localparam int N  = 8;
  localparam int LN = 3;
`ifdef RRARB_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam int LTMO   = 2;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 256;
  localparam int LTMO   = 8;
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_grant_arbiter_if #(.NUM_ENTRY(N), .LOG_NUM_ENTRY(LN)) arb ();

  rr_grant_arbiter #(
    .NUM_ENTRY     (N),
    .LOG_NUM_ENTRY (LN),
    .TIMEOUT       (TMO),
    .LOG_TIMEOUT   (LTMO)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .arb   (arb)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: who owns the resource, who had it last, how long held.
  bit m_busy;
  bit m_tmo;
  int m_owner;
  int m_last;
  int m_held;

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_tmo   = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
    m_held  = 0;
  endfunction

  function automatic void model_clk(input logic [N-1:0] req,
                                     input logic [N-1:0] rls);
    bit gone, tout;
    m_tmo = 1'b0;
    if (!m_busy) begin
      if (req != 0) begin
        for (int k = 1; k <= N; k++) begin
          if (((req >> ((m_last + k) % N)) & 1) != 0) begin
            m_owner = (m_last + k) % N;
            break;
          end
        end
        m_busy = 1'b1;
        m_held = 1;
      end
    end else begin
      gone = ((rls >> m_owner) & 1) != 0 || ((req >> m_owner) & 1) == 0;
      tout = TMO_EN && (m_held == TMO);
      if (gone || tout) begin
        m_busy = 1'b0;
        m_last = m_owner;
        m_tmo  = tout && !gone;
      end else begin
        m_held++;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eg;
    eg = m_busy ? N'(1 << m_owner) : '0;
    chk({tag, "_vld"}, 32'(arb.O_Vld), 32'(m_busy));
    chk({tag, "_grt"}, 32'(arb.O_Grt), 32'(eg));
    chk({tag, "_tmo"}, 32'(arb.O_Tmo), 32'(m_tmo));
    if (m_busy) chk({tag, "_no"}, 32'(arb.O_Grt_No), 32'(m_owner));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) model_clk(arb.I_Req, arb.I_Rls);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_rst_vld"}, 32'(arb.O_Vld), 32'd0);
    chk({tag, "_rst_grt"}, 32'(arb.O_Grt), 32'd0);
    chk({tag, "_rst_tmo"}, 32'(arb.O_Tmo), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [N-1:0] rq;

  initial begin
    arb.I_Req = '0;
    arb.I_Rls = '0;
    model_reset();
    #1;
    chk("reset_vld", 32'(arb.O_Vld), 32'd0);
    chk("reset_no",  32'(arb.O_Grt_No), 32'd0);
    chk("reset_grt", 32'(arb.O_Grt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) step("t1_idle");

    arb.I_Req = 8'h10;
    step("t2_grant");
    chk("t2_grt", 32'(arb.O_Grt), 32'h10);
    chk("t2_no",  32'(arb.O_Grt_No), 32'd4);
    step("t2_hold");
    step("t2_hold");
    arb.I_Rls = 8'h10;
    step("t2_rls");
    chk("t2_rls_vld", 32'(arb.O_Vld), 32'd0);
    arb.I_Rls = '0;
    arb.I_Req = '0;
    step("t2_idle");

    do_reset("t3");
    arb.I_Req = 8'hFF;
    for (int g = 0; g <= N; g++) begin
      step("t3_grant");
      chk("t3_order", 32'(arb.O_Grt_No), 32'(g % N));
      arb.I_Rls = N'(1 << (g % N));
      step("t3_rls");
      chk("t3_gap", 32'(arb.O_Vld), 32'd0);
      arb.I_Rls = '0;
    end
    arb.I_Req = '0;

    arb.I_Req = 8'h04;
    step("t4_grant");
    arb.I_Rls = 8'h08;
    step("t4_foreign");
    chk("t4_keep", 32'(arb.O_Grt), 32'h04);
    arb.I_Rls = '0;
    arb.I_Req = '0;
    step("t4_drop");
    chk("t4_drop_vld", 32'(arb.O_Vld), 32'd0);

    arb.I_Req = 8'h80;
    step("t5_g7");
    arb.I_Rls = 8'h80;
    arb.I_Req = '0;
    step("t5_r7");
    arb.I_Rls = '0;
    arb.I_Req = 8'h81;
    step("t5_wrap");
    chk("t5_wrap_no", 32'(arb.O_Grt_No), 32'd0);
    arb.I_Rls = 8'h01;
    arb.I_Req = 8'h80;
    step("t5_r0");
    arb.I_Rls = '0;
    step("t5_then7");
    chk("t5_then7_no", 32'(arb.O_Grt_No), 32'd7);
    arb.I_Rls = 8'h80;
    arb.I_Req = '0;
    step("t5_end");
    arb.I_Rls = '0;

`ifdef RRARB_TIMEOUT_EN
    arb.I_Req = 8'h18;
    for (int i = 0; i < TMO; i++) begin
      step("t6_hold");
      chk("t6_hold_vld", 32'(arb.O_Vld), 32'd1);
      chk("t6_hold_no",  32'(arb.O_Grt_No), 32'd3);
    end
    step("t6_expire");
    chk("t6_exp_vld", 32'(arb.O_Vld), 32'd0);
    chk("t6_exp_tmo", 32'(arb.O_Tmo), 32'd1);
    step("t6_next");
    chk("t6_next_no", 32'(arb.O_Grt_No), 32'd4);
    arb.I_Req = '0;
    step("t6_end");
`endif

    arb.I_Req = 8'h02;
    step("t7_grant");
    step("t7_hold");
    do_reset("t7");
    step("t7_after");
    step("t7_regrant");
    chk("t7_regrant_no", 32'(arb.O_Grt_No), 32'd1);
    arb.I_Req = '0;
    step("t7_end");

    rq = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rq = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      end
      arb.I_Req = rq;
      arb.I_Rls = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      step("rand");
    end
    arb.I_Req = '0;
    arb.I_Rls = '0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
